// File: rtl/riscv_alu_decode_stage.sv
// RV32I OP/OP-IMM/BRANCH/LUI/AUIPC decode into riscV_alu operator codes and operands; 1-cycle latency, 1 instr/cycle.
// Output reg plus skid reg keep in_ready_o registered; define ALU_DEC_FLUSH_EN to add the flush_i port.
module riscv_alu_decode_stage #(
    parameter int XLEN     = 32,
    parameter int ALU_OP_W = 6
) (
    input  logic                clk_i,
    input  logic                rst_i,
`ifdef ALU_DEC_FLUSH_EN
    input  logic                flush_i,
`endif
    input  logic                in_valid_i,
    output logic                in_ready_o,
    input  logic [31:0]         instr_i,
    input  logic [XLEN-1:0]     pc_i,
    input  logic [XLEN-1:0]     rs1_data_i,
    input  logic [XLEN-1:0]     rs2_data_i,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic [ALU_OP_W-1:0] alu_op_o,
    output logic [XLEN-1:0]     operand_a_o,
    output logic [XLEN-1:0]     operand_b_o,
    output logic [4:0]          rd_addr_o,
    output logic                rd_we_o,
    output logic                branch_o,
    output logic [XLEN-1:0]     branch_target_o,
    output logic                illegal_o
);

    localparam logic [ALU_OP_W-1:0] ALU_ADD = 6'b011000;
    localparam logic [ALU_OP_W-1:0] ALU_SUB = 6'b011001;
    localparam logic [ALU_OP_W-1:0] ALU_XOR = 6'b101111;
    localparam logic [ALU_OP_W-1:0] ALU_OR  = 6'b101110;
    localparam logic [ALU_OP_W-1:0] ALU_AND = 6'b010101;
    localparam logic [ALU_OP_W-1:0] ALU_SRA = 6'b100100;
    localparam logic [ALU_OP_W-1:0] ALU_SRL = 6'b100101;
    localparam logic [ALU_OP_W-1:0] ALU_SLL = 6'b100111;
    localparam logic [ALU_OP_W-1:0] ALU_LTS = 6'b000000;
    localparam logic [ALU_OP_W-1:0] ALU_LTU = 6'b000001;
    localparam logic [ALU_OP_W-1:0] ALU_GES = 6'b001010;
    localparam logic [ALU_OP_W-1:0] ALU_GEU = 6'b001011;
    localparam logic [ALU_OP_W-1:0] ALU_EQ  = 6'b001100;
    localparam logic [ALU_OP_W-1:0] ALU_NE  = 6'b001101;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    typedef struct packed {
        logic [ALU_OP_W-1:0] op;
        logic [XLEN-1:0]     a;
        logic [XLEN-1:0]     b;
        logic [4:0]          rd;
        logic                we;
        logic                br;
        logic [XLEN-1:0]     tgt;
        logic                ill;
    } entry_t;

    entry_t out_q, out_d, skid_q, skid_d, dec;
    logic   out_vld_q, out_vld_d, skid_full_q, skid_full_d;
    logic   flush, accept;

`ifdef ALU_DEC_FLUSH_EN
    assign flush = flush_i;
`else
    assign flush = 1'b0;
`endif

    assign in_ready_o = !skid_full_q && !flush;
    assign accept     = in_valid_i && in_ready_o;

    logic [6:0]          opcode, funct7;
    logic [2:0]          funct3;
    logic [ALU_OP_W-1:0] base_op;
    logic                legal, writes;

    assign opcode = instr_i[6:0];
    assign funct3 = instr_i[14:12];
    assign funct7 = instr_i[31:25];

    always_comb begin
        case (funct3)
            3'b000:  base_op = ALU_ADD;
            3'b001:  base_op = ALU_SLL;
            3'b010:  base_op = ALU_LTS;
            3'b011:  base_op = ALU_LTU;
            3'b100:  base_op = ALU_XOR;
            3'b101:  base_op = ALU_SRL;
            3'b110:  base_op = ALU_OR;
            default: base_op = ALU_AND;
        endcase
    end

    always_comb begin
        dec    = '0;
        dec.op = ALU_ADD;
        dec.rd = instr_i[11:7];
        legal  = 1'b0;
        writes = 1'b0;
        case (opcode)
            OPC_OP: begin
                legal  = (funct7 == 7'h00) ||
                         (funct7 == 7'h20 && (funct3 == 3'b000 || funct3 == 3'b101));
                writes = 1'b1;
                dec.a  = rs1_data_i;
                dec.b  = rs2_data_i;
                if (funct7[5])
                    dec.op = (funct3 == 3'b000) ? ALU_SUB : ALU_SRA;
                else
                    dec.op = base_op;
            end
            OPC_OP_IMM: begin
                writes = 1'b1;
                dec.a  = rs1_data_i;
                dec.op = base_op;
                if (funct3 == 3'b001 || funct3 == 3'b101) begin
                    // Shift-immediates: upper bits select SRAI, anything else is reserved
                    legal = (funct7 == 7'h00) || (funct3 == 3'b101 && funct7 == 7'h20);
                    dec.b = {{(XLEN-5){1'b0}}, instr_i[24:20]};
                    if (funct3 == 3'b101 && funct7[5])
                        dec.op = ALU_SRA;
                end else begin
                    legal = 1'b1;
                    dec.b = {{(XLEN-12){instr_i[31]}}, instr_i[31:20]};
                end
            end
            OPC_BRANCH: begin
                legal  = (funct3 != 3'b010) && (funct3 != 3'b011);
                dec.a  = rs1_data_i;
                dec.b  = rs2_data_i;
                dec.br = 1'b1;
                dec.tgt = pc_i + {{(XLEN-13){instr_i[31]}}, instr_i[31], instr_i[7],
                                  instr_i[30:25], instr_i[11:8], 1'b0};
                case (funct3)
                    3'b000:  dec.op = ALU_EQ;
                    3'b001:  dec.op = ALU_NE;
                    3'b100:  dec.op = ALU_LTS;
                    3'b101:  dec.op = ALU_GES;
                    3'b110:  dec.op = ALU_LTU;
                    default: dec.op = ALU_GEU;
                endcase
            end
            OPC_LUI: begin
                legal  = 1'b1;
                writes = 1'b1;
                dec.b  = {instr_i[31:12], 12'b0};
            end
            OPC_AUIPC: begin
                legal  = 1'b1;
                writes = 1'b1;
                dec.a  = pc_i;
                dec.b  = {instr_i[31:12], 12'b0};
            end
            default: legal = 1'b0;
        endcase
        dec.we = legal && writes && (instr_i[11:7] != 5'd0);
        // Illegal encodings still flow downstream, as a harmless ADD 0,0
        if (!legal) begin
            dec.op  = ALU_ADD;
            dec.a   = '0;
            dec.b   = '0;
            dec.br  = 1'b0;
            dec.tgt = '0;
            dec.ill = 1'b1;
        end
    end

    always_comb begin
        out_d       = out_q;
        out_vld_d   = out_vld_q;
        skid_d      = skid_q;
        skid_full_d = skid_full_q;
        if (flush) begin
            out_vld_d   = 1'b0;
            skid_full_d = 1'b0;
        end else if (!out_vld_q || out_ready_i) begin
            // Skid is only ever full behind a valid output, so it drains first
            if (skid_full_q) begin
                out_d       = skid_q;
                out_vld_d   = 1'b1;
                skid_full_d = 1'b0;
            end else if (accept) begin
                out_d     = dec;
                out_vld_d = 1'b1;
            end else begin
                out_vld_d = 1'b0;
            end
        end else if (accept) begin
            skid_d      = dec;
            skid_full_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            out_q       <= '0;
            out_vld_q   <= 1'b0;
            skid_q      <= '0;
            skid_full_q <= 1'b0;
        end else begin
            out_q       <= out_d;
            out_vld_q   <= out_vld_d;
            skid_q      <= skid_d;
            skid_full_q <= skid_full_d;
        end
    end

    assign out_valid_o     = out_vld_q;
    assign alu_op_o        = out_q.op;
    assign operand_a_o     = out_q.a;
    assign operand_b_o     = out_q.b;
    assign rd_addr_o       = out_q.rd;
    assign rd_we_o         = out_q.we;
    assign branch_o        = out_q.br;
    assign branch_target_o = out_q.tgt;
    assign illegal_o       = out_q.ill;

endmodule

// File: tb/tb_riscv_alu_decode_stage.sv
// Bench for riscv_alu_decode_stage: directed vector table, backpressure/reset sequences, random traffic vs reference model.
module tb_riscv_alu_decode_stage;

    typedef struct packed {
        logic [5:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic        we;
        logic        br;
        logic [31:0] tgt;
        logic        ill;
    } ent_t;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] rs1;
        logic [31:0] rs2;
        ent_t        exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
`ifdef ALU_DEC_FLUSH_EN
    logic        flush = 1'b0;
`endif
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] instr = '0, pc = '0, rs1 = '0, rs2 = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [5:0]  alu_op;
    logic [31:0] op_a, op_b, tgt;
    logic [4:0]  rd_addr;
    logic        rd_we, branch, illegal;

    int errors = 0;
    int checks = 0;
    ent_t q[$];
    vec_t tv[$];

    always #5 clk = ~clk;

    riscv_alu_decode_stage dut (
        .clk_i(clk), .rst_i(rst),
`ifdef ALU_DEC_FLUSH_EN
        .flush_i(flush),
`endif
        .in_valid_i(in_valid), .in_ready_o(in_ready), .instr_i(instr), .pc_i(pc),
        .rs1_data_i(rs1), .rs2_data_i(rs2), .out_valid_o(out_valid), .out_ready_i(out_ready),
        .alu_op_o(alu_op), .operand_a_o(op_a), .operand_b_o(op_b), .rd_addr_o(rd_addr),
        .rd_we_o(rd_we), .branch_o(branch), .branch_target_o(tgt), .illegal_o(illegal)
    );

    function automatic ent_t mk(logic [5:0] op, logic [31:0] a, logic [31:0] b, logic [4:0] rd,
                                logic we, logic br, logic [31:0] t, logic ill);
        ent_t e;
        e.op = op; e.a = a; e.b = b; e.rd = rd; e.we = we; e.br = br; e.tgt = t; e.ill = ill;
        return e;
    endfunction

    // Reference decode, straight from the ISA encoding rules
    function automatic ent_t model(logic [31:0] ins, logic [31:0] p, logic [31:0] r1, logic [31:0] r2);
        logic [5:0] alu_tab [8];
        logic [5:0] br_tab [8];
        logic [6:0] opc, f7;
        logic [2:0] f3;
        logic       ok, wr;
        int         imm;
        ent_t       e;
        alu_tab = '{6'b011000, 6'b100111, 6'b000000, 6'b000001, 6'b101111, 6'b100101, 6'b101110, 6'b010101};
        br_tab  = '{6'b001100, 6'b001101, 6'b011000, 6'b011000, 6'b000000, 6'b001010, 6'b000001, 6'b001011};
        opc = ins[6:0]; f3 = ins[14:12]; f7 = ins[31:25];
        e = mk(6'b011000, 0, 0, ins[11:7], 0, 0, 0, 0);
        ok = 0; wr = 0;
        if (opc == 7'h33) begin
            wr = 1; e.a = r1; e.b = r2; e.op = alu_tab[f3];
            if (f7 == 7'h00) ok = 1;
            else if (f7 == 7'h20 && f3 == 3'd0) begin ok = 1; e.op = 6'b011001; end
            else if (f7 == 7'h20 && f3 == 3'd5) begin ok = 1; e.op = 6'b100100; end
        end else if (opc == 7'h13) begin
            wr = 1; e.a = r1; e.op = alu_tab[f3];
            if (f3 == 3'd1 || f3 == 3'd5) begin
                e.b = 32'(ins[24:20]);
                ok = (f7 == 7'h00) || (f3 == 3'd5 && f7 == 7'h20);
                if (f3 == 3'd5 && f7 == 7'h20) e.op = 6'b100100;
            end else begin
                ok = 1; e.b = $signed(ins) >>> 20;
            end
        end else if (opc == 7'h63) begin
            ok = (f3 != 3'd2) && (f3 != 3'd3);
            e.a = r1; e.b = r2; e.br = 1; e.op = br_tab[f3];
            imm = (ins[31] ? -4096 : 0) + int'(ins[7]) * 2048 + int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2;
            e.tgt = p + 32'(imm);
        end else if (opc == 7'h37 || opc == 7'h17) begin
            ok = 1; wr = 1; e.b = ins & 32'hFFFFF000;
            e.a = (opc == 7'h17) ? p : 32'd0;
        end
        e.we = ok && wr && (ins[11:7] != 0);
        if (!ok) e = mk(6'b011000, 0, 0, ins[11:7], 0, 0, 0, 1);
        return e;
    endfunction

    task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle: drive at negedge, check outputs against the FIFO model, then update it
    task automatic cycle(logic vld, logic [31:0] ins, logic [31:0] p, logic [31:0] r1, logic [31:0] r2,
                         logic ordy, ent_t push);
        ent_t act;
        logic fire, acc;
        @(negedge clk);
        in_valid = vld; instr = ins; pc = p; rs1 = r1; rs2 = r2; out_ready = ordy;
`ifdef ALU_DEC_FLUSH_EN
        flush = 1'b0;
`endif
        #1;
        act = {alu_op, op_a, op_b, rd_addr, rd_we, branch, tgt, illegal};
        chk("out_valid", 128'(out_valid), 128'(q.size() > 0));
        chk("in_ready", 128'(in_ready), 128'(q.size() < 2));
        if (q.size() > 0) chk("entry", 128'(act), 128'(q[0]));
        fire = (q.size() > 0) && ordy;
        acc  = vld && (q.size() < 2);
        if (fire) void'(q.pop_front());
        if (acc) q.push_back(push);
    endtask

    task automatic rnd_cycle(logic vld, logic ordy);
        logic [31:0] ins, r1, r2, p;
        logic [6:0]  opcs [6];
        opcs = '{7'h33, 7'h13, 7'h63, 7'h37, 7'h17, 7'h00};
        ins = $urandom;
        ins[6:0] = opcs[$urandom_range(0, 5)];
        if (ins[6:0] == 7'h00) ins[6:0] = 7'($urandom);
        case ($urandom_range(0, 3))
            0: ins[31:25] = 7'h00;
            1: ins[31:25] = 7'h20;
            default: ;
        endcase
        r1 = $urandom; r2 = $urandom; p = $urandom;
        cycle(vld, ins, p, r1, r2, ordy, model(ins, p, r1, r2));
    endtask

    task automatic fill_two();
        cycle(1, 32'h002081B3, 0, 32'h11, 32'h22, 0, model(32'h002081B3, 0, 32'h11, 32'h22));
        cycle(1, 32'h00310233, 0, 32'h33, 32'h44, 0, model(32'h00310233, 0, 32'h33, 32'h44));
        cycle(0, 0, 0, 0, 0, 0, mk(0, 0, 0, 0, 0, 0, 0, 0));
    endtask

    initial begin
        tv.push_back('{32'h002081B3, 32'h0,   32'h1,        32'h2, mk(6'b011000, 32'h1, 32'h2, 3, 1, 0, 0, 0)});
        tv.push_back('{32'h40435293, 32'h0,   32'hFFFFFFF0, 32'h0, mk(6'b100100, 32'hFFFFFFF0, 32'h4, 5, 1, 0, 0, 0)});
        tv.push_back('{32'h0020C463, 32'h100, 32'hFFFFFFFF, 32'h1, mk(6'b000000, 32'hFFFFFFFF, 32'h1, 8, 0, 1, 32'h108, 0)});
        tv.push_back('{32'h022081B3, 32'h0,   32'h5,        32'h6, mk(6'b011000, 0, 0, 3, 0, 0, 0, 1)});
        tv.push_back('{32'h0020A463, 32'h100, 32'h5,        32'h6, mk(6'b011000, 0, 0, 8, 0, 0, 0, 1)});
        tv.push_back('{32'h402081B3, 32'h0,   32'h5,        32'h7, mk(6'b011001, 32'h5, 32'h7, 3, 1, 0, 0, 0)});
        tv.push_back('{32'h123450B7, 32'h40,  32'h9,        32'h9, mk(6'b011000, 0, 32'h12345000, 1, 1, 0, 0, 0)});
        tv.push_back('{32'hFFFFF117, 32'h40,  32'h9,        32'h9, mk(6'b011000, 32'h40, 32'hFFFFF000, 2, 1, 0, 0, 0)});
        tv.push_back('{32'hFFF00213, 32'h0,   32'h9,        32'h9, mk(6'b011000, 32'h9, 32'hFFFFFFFF, 4, 1, 0, 0, 0)});
        tv.push_back('{32'h00208033, 32'h0,   32'h3,        32'h4, mk(6'b011000, 32'h3, 32'h4, 0, 0, 0, 0, 0)});
        tv.push_back('{32'h40209093, 32'h0,   32'h3,        32'h4, mk(6'b011000, 0, 0, 1, 0, 0, 0, 1)});
        tv.push_back('{32'h0000007F, 32'h0,   32'h3,        32'h4, mk(6'b011000, 0, 0, 0, 0, 0, 0, 1)});
        tv.push_back('{32'hFE209EE3, 32'h200, 32'hA,        32'hB, mk(6'b001101, 32'hA, 32'hB, 29, 0, 1, 32'h1FC, 0)});

        // Reset state, sampled while reset is held
        #3;
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_in_ready", 128'(in_ready), 128'(1));
        chk("rst_data", 128'({alu_op, op_a, op_b, rd_addr, rd_we, branch, tgt, illegal}), 128'(0));
        @(negedge clk);
        rst = 1'b0;

        foreach (tv[i]) begin
            cycle(1, tv[i].instr, tv[i].pc, tv[i].rs1, tv[i].rs2, 1, tv[i].exp);
            cycle(0, 0, 0, 0, 0, 1, mk(0, 0, 0, 0, 0, 0, 0, 0));
        end

        // Three back-to-back ADDs into a stalled stage, then drain
        for (int i = 0; i < 3; i++)
            cycle(1, 32'h002081B3 + (i << 7), 0, i, i + 10, 0, model(32'h002081B3 + (i << 7), 0, i, i + 10));
        cycle(1, 32'h002081B3 + (2 << 7), 0, 2, 12, 0, model(32'h002081B3 + (2 << 7), 0, 2, 12));
        chk("stall_depth", 128'(q.size()), 128'(2));
        for (int i = 0; i < 4; i++)
            cycle(i < 2, 32'h002081B3 + (2 << 7), 0, 2, 12, 1, model(32'h002081B3 + (2 << 7), 0, 2, 12));
        chk("drained", 128'(q.size()), 128'(0));

        // Asynchronous reset with both entries occupied
        fill_two();
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midrst_out_valid", 128'(out_valid), 128'(0));
        chk("midrst_in_ready", 128'(in_ready), 128'(1));
        q.delete();
        @(negedge clk);
        rst = 1'b0;
        cycle(0, 0, 0, 0, 0, 1, mk(0, 0, 0, 0, 0, 0, 0, 0));

`ifdef ALU_DEC_FLUSH_EN
        fill_two();
        @(negedge clk);
        flush = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
        #1;
        chk("flush_in_ready", 128'(in_ready), 128'(0));
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        #1;
        chk("flush_out_valid", 128'(out_valid), 128'(0));
        q.delete();
        cycle(0, 0, 0, 0, 0, 1, mk(0, 0, 0, 0, 0, 0, 0, 0));
`endif

        for (int i = 0; i < 3000; i++)
            rnd_cycle($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0);
        for (int i = 0; i < 4; i++)
            cycle(0, 0, 0, 0, 0, 1, mk(0, 0, 0, 0, 0, 0, 0, 0));
        chk("final_empty", 128'(q.size()), 128'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
